// File: rtl/counter_access_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_arb_pkg
// Description : Shared operation/state encodings for counter_access_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_arb_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_INC  = 2'b01,
        OP_DEC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ACK  = 2'b10
    } state_e;

    localparam int c_NREQ_MIN = 2;
    localparam int c_NREQ_MAX = 8;

    // Requester index width; never below one bit so NREQ=2 still gets a real pointer.
    function automatic int ptr_width(input int n);
        return (n <= c_NREQ_MIN) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/counter_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_access_arbiter_if
// Description : Requester-side bus of the shared counter (req/op/din in, ack/data out).
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_access_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] din;
    logic                  ovf_clr;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      rdata;
    logic [WIDTH-1:0]      count;
    logic                  wrap;
    logic                  ovf_sticky;

    modport master (
        output req, op, din, ovf_clr,
        input  ack, rdata, count, wrap, ovf_sticky
    );

    modport slave (
        input  req, op, din, ovf_clr,
        output ack, rdata, count, wrap, ovf_sticky
    );
endinterface
`default_nettype wire

// File: rtl/counter_access_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin pick: first set req at or above rr_ptr, modulo NREQ.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] gnt_id,
    output logic             gnt_any
);

    // Walk offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        gnt_id  = '0;
        gnt_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i] && (i == ((int'(rr_ptr) + k) % NREQ))) begin
                    gnt_id  = PTR_W'(i);
                    gnt_any = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : counter_access_arbiter
// Description : Shared WIDTH-bit counter serving NREQ requesters through a
//               round-robin IDLE/EXEC/ACK sequencer, with wrap and sticky flags.
//               Define COUNTER_ARB_SAT_EN to saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_access_arbiter
    import counter_arb_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int RST_VAL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    counter_access_arbiter_if.slave  bus
);

    localparam int                 c_PTR_W     = ptr_width(NREQ);
    localparam logic [c_PTR_W-1:0] c_LAST_ID   = c_PTR_W'(NREQ - 1);
    localparam logic [WIDTH-1:0]   c_RST_COUNT = WIDTH'(RST_VAL);
    localparam logic [WIDTH:0]     c_ONE_EXT   = {{WIDTH{1'b0}}, 1'b1};

    state_e             r_state, w_state_nxt;
    logic [c_PTR_W-1:0] r_gnt_id, w_gnt_id_nxt;
    logic [c_PTR_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
    op_e                r_op, w_op_nxt;
    logic [WIDTH-1:0]   r_din, w_din_nxt;
    logic [WIDTH-1:0]   r_count, w_count_nxt;
    logic [WIDTH-1:0]   r_rdata, w_rdata_nxt;
    logic [NREQ-1:0]    r_ack, w_ack_nxt;
    logic               r_wrap, w_wrap_nxt;
    logic               r_ovf_sticky, w_ovf_nxt;

    logic [c_PTR_W-1:0] w_arb_id;
    logic               w_arb_any;
    op_e                w_sel_op;
    logic [WIDTH-1:0]   w_sel_din;
    logic [WIDTH:0]     w_inc;
    logic [WIDTH:0]     w_dec;
    logic [WIDTH-1:0]   w_op_result;
    logic               w_op_wrap;

    rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (c_PTR_W)
    ) u_rr_arbiter (
        .req     (bus.req),
        .rr_ptr  (r_rr_ptr),
        .gnt_id  (w_arb_id),
        .gnt_any (w_arb_any)
    );

    always_comb begin
        w_sel_op  = OP_RD;
        w_sel_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_arb_id == c_PTR_W'(i)) begin
                w_sel_op  = op_e'(bus.op[2*i +: 2]);
                w_sel_din = bus.din[WIDTH*i +: WIDTH];
            end
        end
    end

    // Extra MSB of the extended sum/difference is the carry/borrow out.
    assign w_inc = {1'b0, r_count} + c_ONE_EXT;
    assign w_dec = {1'b0, r_count} - c_ONE_EXT;

    always_comb begin
        w_op_result = r_count;
        w_op_wrap   = 1'b0;
        case (r_op)
            OP_INC: begin
                w_op_wrap = w_inc[WIDTH];
`ifdef COUNTER_ARB_SAT_EN
                w_op_result = w_inc[WIDTH] ? r_count : w_inc[WIDTH-1:0];
`else
                w_op_result = w_inc[WIDTH-1:0];
`endif
            end
            OP_DEC: begin
                w_op_wrap = w_dec[WIDTH];
`ifdef COUNTER_ARB_SAT_EN
                w_op_result = w_dec[WIDTH] ? r_count : w_dec[WIDTH-1:0];
`else
                w_op_result = w_dec[WIDTH-1:0];
`endif
            end
            OP_LOAD: w_op_result = r_din;
            default: w_op_result = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_id_nxt = r_gnt_id;
        w_op_nxt     = r_op;
        w_din_nxt    = r_din;
        w_count_nxt  = r_count;
        w_rdata_nxt  = r_rdata;
        w_ack_nxt    = '0;
        w_wrap_nxt   = 1'b0;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_any) begin
                    w_gnt_id_nxt = w_arb_id;
                    w_op_nxt     = w_sel_op;
                    w_din_nxt    = w_sel_din;
                    w_state_nxt  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_count_nxt = w_op_result;
                w_rdata_nxt = w_op_result;
                w_wrap_nxt  = w_op_wrap;
                for (int i = 0; i < NREQ; i++) begin
                    w_ack_nxt[i] = (r_gnt_id == c_PTR_W'(i));
                end
                w_rr_ptr_nxt = (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + c_PTR_W'(1);
                w_state_nxt  = ST_ACK;
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        // Wrap wins over clear both on the wrap edge and while the wrap pulse is visible.
        w_ovf_nxt = (r_ovf_sticky & ~bus.ovf_clr) | w_wrap_nxt | r_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_gnt_id     <= '0;
            r_rr_ptr     <= '0;
            r_op         <= OP_RD;
            r_din        <= '0;
            r_count      <= c_RST_COUNT;
            r_rdata      <= '0;
            r_ack        <= '0;
            r_wrap       <= 1'b0;
            r_ovf_sticky <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_gnt_id     <= w_gnt_id_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_op         <= w_op_nxt;
            r_din        <= w_din_nxt;
            r_count      <= w_count_nxt;
            r_rdata      <= w_rdata_nxt;
            r_ack        <= w_ack_nxt;
            r_wrap       <= w_wrap_nxt;
            r_ovf_sticky <= w_ovf_nxt;
        end
    end

    assign bus.ack        = r_ack;
    assign bus.rdata      = r_rdata;
    assign bus.count      = r_count;
    assign bus.wrap       = r_wrap;
    assign bus.ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire
